// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared constants, address-field slices, FSM state type and
//                a line-address helper for the data-cache controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

   // Geometry
   localparam int ADDR_W      = 32;
   localparam int IDX_W       = 4;
   localparam int OFS_W       = 5;
   localparam int LINE_W      = 256;
   localparam int TAG_ENTRY_W = 25;
   localparam int WORD_W      = 32;
   localparam int WORDS       = LINE_W / WORD_W;
   localparam int WSEL_W      = 3;
   localparam int TAG_W       = ADDR_W - IDX_W - OFS_W;

   // Tag-entry bit positions
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;
   localparam int TAG_MSB   = 22;

   // CPU byte-address field slices
   localparam int ADDR_TAG_MSB  = 31;
   localparam int ADDR_TAG_LSB  = 9;
   localparam int ADDR_IDX_MSB  = 8;
   localparam int ADDR_IDX_LSB  = 5;
   localparam int ADDR_WORD_MSB = 4;
   localparam int ADDR_WORD_LSB = 2;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_MISS        = 3'd1,
      ST_WRITEBACK   = 3'd2,
      ST_REFILL      = 3'd3,
      ST_REFILL_DONE = 3'd4
   } state_t;

   // Line-aligned memory address from a tag and a set index
   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFS_W{1'b0}}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_if
//  Description : CPU, SRAM-array and memory-port signals of the data-cache
//                controller. master = controller side, slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dcache_if;
   import dcache_pkg::*;

   // CPU load/store port
   logic                   cpu_req_i;
   logic                   cpu_we_i;
   logic [ADDR_W-1:0]      cpu_addr_i;
   logic [WORD_W-1:0]      cpu_data_i;
   logic [WORD_W-1:0]      cpu_data_o;
   logic                   cpu_stall_o;

   // Cache SRAM array
   logic                   sram_enable_o;
   logic                   sram_write_o;
   logic [IDX_W-1:0]       sram_addr_o;
   logic [TAG_ENTRY_W-1:0] sram_tag_o;
   logic [LINE_W-1:0]      sram_data_o;
   logic [TAG_ENTRY_W-1:0] sram_tag_i;
   logic [LINE_W-1:0]      sram_data_i;
   logic                   sram_hit_i;

   // Off-chip data memory
   logic                   mem_enable_o;
   logic                   mem_write_o;
   logic [ADDR_W-1:0]      mem_addr_o;
   logic [LINE_W-1:0]      mem_data_o;
   logic [LINE_W-1:0]      mem_data_i;
   logic                   mem_ack_i;

   modport master (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
      output cpu_data_o, cpu_stall_o,
      output sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
      input  sram_tag_i, sram_data_i, sram_hit_i,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i
   );

   modport slave (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
      input  cpu_data_o, cpu_stall_o,
      input  sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
      output sram_tag_i, sram_data_i, sram_hit_i,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i
   );

endinterface
`default_nettype wire

// File: rtl/dcache_word_merge.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_word_merge
//  Description : Combinational 32-bit word select (loads) and word replace
//                (stores) within a 256-bit cache line.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_word_merge
   import dcache_pkg::*;
(
   input  wire logic [LINE_W-1:0] line_i,
   input  wire logic [WSEL_W-1:0] sel_i,
   input  wire logic [WORD_W-1:0] wdata_i,
   output logic      [WORD_W-1:0] rdata_o,
   output logic      [LINE_W-1:0] line_o
);

   // Selected word for load data
   assign rdata_o = line_i[int'(sel_i)*WORD_W +: WORD_W];

   // Line with the selected word replaced by the store data
   for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      assign line_o[gi*WORD_W +: WORD_W] =
         (sel_i == WSEL_W'(gi)) ? wdata_i : line_i[gi*WORD_W +: WORD_W];
   end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_controller
//  Description : Sequencer for a 2-way set-associative data-cache SRAM.
//                Serves hits in zero stall cycles and runs the miss flow:
//                dirty-victim write-back, line refill, then re-issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller
   import dcache_pkg::*;
(
   input  wire logic clk_i,
   input  wire logic rst_i,
   dcache_if.master  bus
);

   state_t                 r_state;
   state_t                 w_next;
   logic [ADDR_W-1:0]      r_addr;
   logic [TAG_ENTRY_W-1:0] r_victim_tag;
   logic [LINE_W-1:0]      r_victim_line;
   logic [LINE_W-1:0]      r_refill_line;

   logic [ADDR_W-1:0]      w_addr;
   logic [TAG_W-1:0]       w_tag;
   logic [IDX_W-1:0]       w_idx;
   logic [WSEL_W-1:0]      w_word;
   logic [WORD_W-1:0]      w_rd_word;
   logic [LINE_W-1:0]      w_merged;
   logic                   w_victim_dirty;

   // CPU inputs are only looked at in IDLE; a miss works on the latched address
   assign w_addr = (r_state == ST_IDLE) ? bus.cpu_addr_i : r_addr;
   assign w_tag  = w_addr[ADDR_TAG_MSB:ADDR_TAG_LSB];
   assign w_idx  = w_addr[ADDR_IDX_MSB:ADDR_IDX_LSB];
   assign w_word = w_addr[ADDR_WORD_MSB:ADDR_WORD_LSB];

   assign bus.sram_addr_o = w_idx;
   assign w_victim_dirty  = bus.sram_tag_i[VALID_BIT] & bus.sram_tag_i[DIRTY_BIT];

   dcache_word_merge u_merge (
      .line_i  (bus.sram_data_i),
      .sel_i   (w_word),
      .wdata_i (bus.cpu_data_i),
      .rdata_o (w_rd_word),
      .line_o  (w_merged)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Miss-flow captures: request address, LRU victim, refill line
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_addr        <= '0;
         r_victim_tag  <= '0;
         r_victim_line <= '0;
         r_refill_line <= '0;
      end else begin
         if (r_state == ST_IDLE && bus.cpu_req_i && !bus.sram_hit_i)
            r_addr <= bus.cpu_addr_i;
         if (r_state == ST_MISS) begin
            r_victim_tag  <= bus.sram_tag_i;
            r_victim_line <= bus.sram_data_i;
         end
         if (r_state == ST_REFILL && bus.mem_ack_i)
            r_refill_line <= bus.mem_data_i;
      end
   end

   // Next state and all controller outputs
   always_comb begin
      w_next            = r_state;
      bus.cpu_stall_o   = 1'b0;
      bus.cpu_data_o    = '0;
      bus.sram_enable_o = 1'b0;
      bus.sram_write_o  = 1'b0;
      bus.sram_tag_o    = {1'b1, 1'b0, w_tag};
      bus.sram_data_o   = '0;
      bus.mem_enable_o  = 1'b0;
      bus.mem_write_o   = 1'b0;
      bus.mem_addr_o    = '0;
      bus.mem_data_o    = '0;
      case (r_state)
         ST_IDLE: begin
            if (bus.cpu_req_i) begin
               bus.sram_enable_o = 1'b1;
               bus.sram_tag_o    = {1'b1, bus.cpu_we_i, w_tag};
               if (bus.sram_hit_i) begin
                  if (bus.cpu_we_i) begin
                     bus.sram_write_o = 1'b1;
                     bus.sram_data_o  = w_merged;
                  end else begin
                     bus.cpu_data_o = w_rd_word;
                  end
               end else begin
                  bus.cpu_stall_o = 1'b1;
                  w_next          = ST_MISS;
               end
            end
         end
         ST_MISS: begin
            // SRAM presents the LRU victim of the latched set this cycle
            bus.cpu_stall_o   = 1'b1;
            bus.sram_enable_o = 1'b1;
            w_next            = w_victim_dirty ? ST_WRITEBACK : ST_REFILL;
         end
         ST_WRITEBACK: begin
            bus.cpu_stall_o  = 1'b1;
            bus.mem_enable_o = 1'b1;
            bus.mem_write_o  = 1'b1;
            bus.mem_addr_o   = line_addr(r_victim_tag[TAG_MSB:0], w_idx);
            bus.mem_data_o   = r_victim_line;
            if (bus.mem_ack_i) w_next = ST_REFILL;
         end
         ST_REFILL: begin
            bus.cpu_stall_o  = 1'b1;
            bus.mem_enable_o = 1'b1;
            bus.mem_addr_o   = line_addr(w_tag, w_idx);
            if (bus.mem_ack_i) w_next = ST_REFILL_DONE;
         end
         ST_REFILL_DONE: begin
            // Install the clean line; the request replays as a hit in IDLE
            bus.cpu_stall_o   = 1'b1;
            bus.sram_enable_o = 1'b1;
            bus.sram_write_o  = 1'b1;
            bus.sram_data_o   = r_refill_line;
            bus.sram_tag_o    = {1'b1, 1'b0, w_tag};
            w_next            = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_controller
//  Description : Directed self-checking bench with a behavioural 2-way LRU
//                SRAM model and a latency-programmable memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   dcache_if bus();

   dcache_controller u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural SRAM: 2 ways x 16 sets, 1 LRU bit per set
   logic [24:0]  m_tag  [0:1][0:15];
   logic [255:0] m_data [0:1][0:15];
   logic         m_lru  [0:15];
   logic         model_clr;
   logic         w_h0, w_h1, w_way;
   logic [3:0]   w_s;

   // Hit lookup against the compare tag; on miss present the LRU way
   always_comb begin
      w_s  = bus.sram_addr_o;
      w_h0 = m_tag[0][w_s][24] && (m_tag[0][w_s][22:0] == bus.sram_tag_o[22:0]);
      w_h1 = m_tag[1][w_s][24] && (m_tag[1][w_s][22:0] == bus.sram_tag_o[22:0]);
      w_way = w_h0 ? 1'b0 : (w_h1 ? 1'b1 : m_lru[w_s]);
      bus.sram_hit_i  = w_h0 | w_h1;
      bus.sram_tag_i  = m_tag[w_way][w_s];
      bus.sram_data_i = m_data[w_way][w_s];
   end

   // Array writes and LRU update
   always @(posedge clk) begin
      if (model_clr) begin
         for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++) begin
               m_tag[w][s]  <= '0;
               m_data[w][s] <= '0;
            end
         for (int s = 0; s < 16; s++) m_lru[s] <= 1'b0;
      end else if (bus.sram_enable_o) begin
         if (bus.sram_write_o) begin
            m_tag[w_way][w_s]  <= bus.sram_tag_o;
            m_data[w_way][w_s] <= bus.sram_data_o;
         end
         if (bus.sram_hit_i || bus.sram_write_o) m_lru[w_s] <= ~w_way;
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Run one CPU access until stall drops, answering memory requests.
   // Latencies count cycles with mem_enable_o high, the ack cycle included.
   task automatic run_access(input int lat_wb, input int lat_rf, input logic [255:0] rf_line,
                             output int stalls, output int ntx,
                             output logic [31:0] a0, output logic w0,
                             output logic [31:0] a1, output logic w1,
                             output logic [255:0] wb_data, output int errs);
      int cnt;
      bit after_rd_ack;
      stalls = 0; ntx = 0; cnt = 0; errs = 0; after_rd_ack = 0;
      a0 = '0; a1 = '0; w0 = 1'b0; w1 = 1'b0; wb_data = '0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         bus.mem_ack_i = 1'b0;
         if (after_rd_ack && bus.mem_enable_o) errs++;
         after_rd_ack = 0;
         if (!bus.cpu_stall_o) return;
         stalls++;
         if (bus.mem_enable_o) begin
            if (cnt == 0) begin
               ntx++;
               if (ntx == 1) begin a0 = bus.mem_addr_o; w0 = bus.mem_write_o; end
               else          begin a1 = bus.mem_addr_o; w1 = bus.mem_write_o; end
               if (bus.mem_write_o) wb_data = bus.mem_data_o;
            end
            cnt++;
            if (cnt == (bus.mem_write_o ? lat_wb : lat_rf)) begin
               bus.mem_ack_i = 1'b1;
               if (!bus.mem_write_o) begin
                  bus.mem_data_i = rf_line;
                  after_rd_ack   = 1;
               end
               cnt = 0;
            end
         end else if (cnt != 0) begin
            errs++;
         end
      end
      errs++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, nt, errs;
      logic [31:0] a0, a1;
      logic w0, w1;
      logic [255:0] wbd, line1, line2, line3;

      for (int i = 0; i < 8; i++) begin
         line1[i*32 +: 32] = 32'hA000_0000 + i;
         line2[i*32 +: 32] = 32'hB000_0000 + i;
         line3[i*32 +: 32] = 32'hC000_0000 + i;
      end
      line1[63:32] = 32'hDEAD_BEEF;

      rst = 1'b1; model_clr = 1'b1;
      bus.cpu_req_i = 0; bus.cpu_we_i = 0; bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
      bus.mem_data_i = '0; bus.mem_ack_i = 0;
      repeat (2) @(posedge clk);
      #1 model_clr = 1'b0;
      @(negedge clk);
      check("rst_stall", 256'(bus.cpu_stall_o), 256'(0));
      check("rst_mem_en", 256'(bus.mem_enable_o), 256'(0));
      check("rst_sram_en", 256'(bus.sram_enable_o), 256'(0));
      @(posedge clk); #1 rst = 1'b0;

      // Load miss, clean victim: 0x124 -> set 9, word 1
      bus.cpu_addr_i = 32'h124; bus.cpu_we_i = 0; bus.cpu_req_i = 1;
      run_access(0, 4, line1, st, nt, a0, w0, a1, w1, wbd, errs);
      check("ld_miss_stalls", 256'(st), 256'(7));
      check("ld_miss_ntx", 256'(nt), 256'(1));
      check("ld_miss_addr", 256'(a0), 256'(32'h120));
      check("ld_miss_wr", 256'(w0), 256'(0));
      check("ld_miss_proto", 256'(errs), 256'(0));
      check("ld_miss_data", 256'(bus.cpu_data_o), 256'(32'hDEAD_BEEF));
      check("ld_sram_addr", 256'(bus.sram_addr_o), 256'(9));
      @(posedge clk); #1 bus.cpu_req_i = 0;

      // Store hit to 0x124
      bus.cpu_we_i = 1; bus.cpu_data_i = 32'h1234_5678; bus.cpu_req_i = 1;
      @(negedge clk);
      check("st_hit_stall", 256'(bus.cpu_stall_o), 256'(0));
      check("st_hit_wr", 256'(bus.sram_write_o), 256'(1));
      check("st_hit_tag", 256'(bus.sram_tag_o), 256'(25'h180_0000));
      check("st_hit_w1", 256'(bus.sram_data_o[63:32]), 256'(32'h1234_5678));
      check("st_hit_w0", 256'(bus.sram_data_o[31:0]), 256'(32'hA000_0000));
      @(posedge clk); #1 bus.cpu_we_i = 0;
      @(negedge clk);
      check("ld_hit_stall", 256'(bus.cpu_stall_o), 256'(0));
      check("ld_hit_data", 256'(bus.cpu_data_o), 256'(32'h1234_5678));
      check("ld_hit_cmp_tag", 256'(bus.sram_tag_o), 256'(25'h100_0000));
      @(posedge clk); #1 bus.cpu_req_i = 0;

      // Store miss tag 1 set 9 into the empty way, then store hit
      bus.cpu_addr_i = 32'h320; bus.cpu_we_i = 1; bus.cpu_data_i = 32'hCAFE_F00D; bus.cpu_req_i = 1;
      run_access(0, 2, line2, st, nt, a0, w0, a1, w1, wbd, errs);
      check("st_miss_stalls", 256'(st), 256'(5));
      check("st_miss_addr", 256'(a0), 256'(32'h320));
      check("st_miss_proto", 256'(errs), 256'(0));
      check("st_replay_wr", 256'(bus.sram_write_o), 256'(1));
      check("st_replay_tag", 256'(bus.sram_tag_o), 256'(25'h180_0001));
      @(posedge clk); #1 bus.cpu_req_i = 0; bus.cpu_we_i = 0;

      // Load tag 2 set 9: dirty LRU victim (tag 0) written back, 10-cycle ack
      bus.cpu_addr_i = 32'h520; bus.cpu_req_i = 1;
      run_access(10, 3, line3, st, nt, a0, w0, a1, w1, wbd, errs);
      check("evict_stalls", 256'(st), 256'(16));
      check("evict_ntx", 256'(nt), 256'(2));
      check("evict_wb_addr", 256'(a0), 256'(32'h120));
      check("evict_wb_wr", 256'(w0), 256'(1));
      check("evict_wb_w1", 256'(wbd[63:32]), 256'(32'h1234_5678));
      check("evict_rf_addr", 256'(a1), 256'(32'h520));
      check("evict_rf_wr", 256'(w1), 256'(0));
      check("evict_proto", 256'(errs), 256'(0));
      check("evict_data", 256'(bus.cpu_data_o), 256'(32'hC000_0000));
      @(posedge clk); #1 bus.cpu_req_i = 0;

      // Load tag 3 set 9: dirty victim tag 1, reset during WRITEBACK
      bus.cpu_addr_i = 32'h720; bus.cpu_req_i = 1;
      @(negedge clk);
      check("rw_idle_stall", 256'(bus.cpu_stall_o), 256'(1));
      @(negedge clk);
      check("rw_miss_mem_en", 256'(bus.mem_enable_o), 256'(0));
      @(negedge clk);
      check("rw_wb_en", 256'(bus.mem_enable_o), 256'(1));
      check("rw_wb_wr", 256'(bus.mem_write_o), 256'(1));
      check("rw_wb_addr", 256'(bus.mem_addr_o), 256'(32'h320));
      @(posedge clk); #1 rst = 1'b1; bus.cpu_req_i = 0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rw_mem_en", 256'(bus.mem_enable_o), 256'(0));
      check("rw_stall", 256'(bus.cpu_stall_o), 256'(0));
      check("rw_sram_en", 256'(bus.sram_enable_o), 256'(0));
      bus.mem_ack_i = 1;
      @(negedge clk);
      bus.mem_ack_i = 0;
      check("late_ack_mem_en", 256'(bus.mem_enable_o), 256'(0));
      check("late_ack_stall", 256'(bus.cpu_stall_o), 256'(0));

      // Spurious ack in IDLE with no request
      bus.mem_ack_i = 1;
      @(negedge clk);
      check("spur_sram_wr", 256'(bus.sram_write_o), 256'(0));
      check("spur_sram_en", 256'(bus.sram_enable_o), 256'(0));
      bus.mem_ack_i = 0;
      @(negedge clk);
      check("spur_mem_en", 256'(bus.mem_enable_o), 256'(0));

      // Earlier stored line still a zero-stall hit after all of the above
      @(posedge clk); #1 bus.cpu_addr_i = 32'h320; bus.cpu_req_i = 1;
      @(negedge clk);
      check("post_hit_stall", 256'(bus.cpu_stall_o), 256'(0));
      check("post_hit_data", 256'(bus.cpu_data_o), 256'(32'hCAFE_F00D));
      @(posedge clk); #1 bus.cpu_req_i = 0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
